// File: rtl/expr_eval_pkg.sv
// Shared types and character classes for the streaming expression evaluator.
package expr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NUM,
    ST_SPC,
    ST_OP,
    ST_ERR
  } state_e;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_SPACE = 8'h20;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_0) && (c <= CH_9);
  endfunction

  function automatic logic is_op(input logic [7:0] c);
    return (c == CH_PLUS) || (c == CH_MINUS) || (c == CH_STAR);
  endfunction

endpackage

// File: rtl/expr_eval_mac.sv
// Signed y = a*b + c with overflow detect; EXPR_SAT_EN selects saturation, else wrap.
module expr_mac #(
  parameter int unsigned WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  input  logic signed [WIDTH-1:0] c_i,
  output logic signed [WIDTH-1:0] y_o,
  output logic                    ovf_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0]    ax, bx, pfull;
  logic        [WIDTH:0]   upper;
  logic                    mul_ovf, add_ovf;
  logic signed [WIDTH-1:0] p;
  logic        [WIDTH:0]   s;

  always_comb begin
    ax      = {{WIDTH{a_i[WIDTH-1]}}, a_i};
    bx      = {{WIDTH{b_i[WIDTH-1]}}, b_i};
    pfull   = ax * bx;
    upper   = pfull[PW-1:WIDTH-1];
    mul_ovf = !((&upper) || (~|upper));
    p       = pfull[WIDTH-1:0];
`ifdef EXPR_SAT_EN
    if (mul_ovf) p = pfull[PW-1] ? SMIN : SMAX;
`endif
    // Add operates on the already wrapped/saturated product, one step at a time.
    s       = {p[WIDTH-1], p} + {c_i[WIDTH-1], c_i};
    add_ovf = s[WIDTH] != s[WIDTH-1];
    y_o     = s[WIDTH-1:0];
`ifdef EXPR_SAT_EN
    if (add_ovf) y_o = s[WIDTH] ? SMIN : SMAX;
`endif
    ovf_o   = mul_ovf | add_ovf;
  end

endmodule

// File: rtl/expr_eval.sv
// Streaming ASCII expression recogniser/evaluator (+,-,* with precedence).
// Define EXPR_SAT_EN for saturating arithmetic; default wraps modulo 2^WIDTH.
module expr_eval
  import expr_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic                    in_valid,
  input  logic [7:0]              in,
  output logic                    out,
  output logic signed [WIDTH-1:0] result,
  output logic                    err,
  output logic                    overflow
);

  localparam logic signed [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [WIDTH-1:0] TEN  = WIDTH'(10);
  localparam logic [3:0]              MAXD = 4'(MAX_DIGITS);

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic signed [WIDTH-1:0] acc_q, acc_d, prod_q, prod_d, num_q, num_d;
  logic signed [WIDTH-1:0] result_q, res_d, num_dig, prod_mul, dval;
  logic                    out_q, err_q, ovf_q;
  logic                    upd, ovf_step, ovf_dig, ovf_mul, ovf_res;

  assign dval = {{(WIDTH-4){1'b0}}, in[3:0]};

  expr_mac #(.WIDTH(WIDTH)) u_mac_dig (
    .a_i(num_q), .b_i(TEN), .c_i(dval), .y_o(num_dig), .ovf_o(ovf_dig)
  );

  expr_mac #(.WIDTH(WIDTH)) u_mac_mul (
    .a_i(prod_q), .b_i(num_q), .c_i('0), .y_o(prod_mul), .ovf_o(ovf_mul)
  );

  expr_mac #(.WIDTH(WIDTH)) u_mac_res (
    .a_i(prod_d), .b_i(num_d), .c_i(acc_d), .y_o(res_d), .ovf_o(ovf_res)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    num_d    = num_q;
    upd      = 1'b0;
    ovf_step = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        ST_IDLE, ST_OP: begin
          if (is_digit(in)) begin
            state_d  = ST_NUM;
            cnt_d    = 4'd1;
            num_d    = num_dig;
            ovf_step = ovf_dig;
            upd      = 1'b1;
          end else if (in != CH_SPACE) begin
            state_d = ST_ERR;
          end
        end
        ST_NUM, ST_SPC: begin
          if (is_digit(in) && state_q == ST_NUM && cnt_q != MAXD) begin
            cnt_d    = cnt_q + 4'd1;
            num_d    = num_dig;
            ovf_step = ovf_dig;
            upd      = 1'b1;
          end else if (is_op(in)) begin
            // result_q already holds acc + prod*num, so it is the new accumulator.
            if (in == CH_STAR) begin
              prod_d   = prod_mul;
              ovf_step = ovf_mul;
            end else begin
              acc_d  = result_q;
              prod_d = (in == CH_MINUS) ? '1 : ONE;
            end
            num_d   = '0;
            state_d = ST_OP;
            upd     = 1'b1;
          end else if (in == CH_SPACE) begin
            state_d = ST_SPC;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_ERR: ;
        default: state_d = ST_ERR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      prod_q   <= ONE;
      num_q    <= '0;
      result_q <= '0;
      out_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (in_valid) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      num_q   <= num_d;
      out_q   <= (state_d == ST_NUM) || (state_d == ST_SPC);
      err_q   <= (state_d == ST_ERR);
      if (upd) begin
        result_q <= res_d;
        ovf_q    <= ovf_q | ovf_step | ovf_res;
      end
    end
  end

  assign out      = out_q;
  assign result   = result_q;
  assign err      = err_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_expr_eval.sv
// Bench for expr_eval: a 16-bit/4-digit and an 8-bit/3-digit instance share one stimulus stream.
module tb_expr_eval;

  localparam int S_IDLE = 0, S_NUM = 1, S_SPC = 2, S_OP = 3, S_ERR = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] din = 8'h00;
  logic out_a, err_a, ovf_a, out_b, err_b, ovf_b;
  logic signed [15:0] res_a;
  logic signed [7:0]  res_b;

  int errors = 0;
  int checks = 0;

  int     m_w[2]  = '{16, 8};
  int     m_md[2] = '{4, 3};
  int     m_st[2], m_cnt[2];
  longint m_acc[2], m_prod[2], m_num[2], m_res[2];
  bit     m_ovf[2];

  always #5 clk = ~clk;

  expr_eval #(.WIDTH(16), .MAX_DIGITS(4)) u_a (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(din),
    .out(out_a), .result(res_a), .err(err_a), .overflow(ovf_a)
  );

  expr_eval #(.WIDTH(8), .MAX_DIGITS(3)) u_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(din),
    .out(out_b), .result(res_b), .err(err_b), .overflow(ovf_b)
  );

  function automatic longint fit(int k, longint v);
    longint hi = (longint'(1) << (m_w[k] - 1)) - 1;
    longint lo = -(longint'(1) << (m_w[k] - 1));
    longint m  = longint'(1) << m_w[k];
    if (v > hi || v < lo) begin
      m_ovf[k] = 1'b1;
`ifdef EXPR_SAT_EN
      v = (v > hi) ? hi : lo;
`else
      v = ((v % m) + m) % m;
      if (v > hi) v = v - m;
`endif
    end
    return v;
  endfunction

  function automatic longint mac(int k, longint a, longint b, longint c);
    longint p = fit(k, a * b);
    return fit(k, p + c);
  endfunction

  function automatic void mreset(int k);
    m_st[k] = S_IDLE; m_cnt[k] = 0; m_acc[k] = 0; m_prod[k] = 1;
    m_num[k] = 0; m_res[k] = 0; m_ovf[k] = 1'b0;
  endfunction

  function automatic void mop(int k, byte c);
    if (c == "*") m_prod[k] = mac(k, m_prod[k], m_num[k], 0);
    else begin
      m_acc[k]  = mac(k, m_prod[k], m_num[k], m_acc[k]);
      m_prod[k] = (c == "-") ? -1 : 1;
    end
    m_num[k] = 0;
    m_st[k]  = S_OP;
    m_res[k] = mac(k, m_prod[k], m_num[k], m_acc[k]);
  endfunction

  function automatic void mstep(int k, byte c);
    bit dig = (c >= "0") && (c <= "9");
    bit op  = (c == "+") || (c == "-") || (c == "*");
    bit sp  = (c == " ");
    bit take_digit = 1'b0;
    case (m_st[k])
      S_IDLE, S_OP: begin
        if (dig) begin m_cnt[k] = 0; take_digit = 1'b1; end
        else if (!sp) m_st[k] = S_ERR;
      end
      S_NUM: begin
        if (dig) begin
          if (m_cnt[k] == m_md[k]) m_st[k] = S_ERR;
          else take_digit = 1'b1;
        end else if (op) mop(k, c);
        else if (sp) m_st[k] = S_SPC;
        else m_st[k] = S_ERR;
      end
      S_SPC: begin
        if (op) mop(k, c);
        else if (!sp) m_st[k] = S_ERR;
      end
      default: ;
    endcase
    if (take_digit) begin
      m_num[k] = mac(k, m_num[k], 10, longint'(c) - 48);
      m_cnt[k] = m_cnt[k] + 1;
      m_st[k]  = S_NUM;
      m_res[k] = mac(k, m_prod[k], m_num[k], m_acc[k]);
    end
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic compare_all();
    chk("a_out", {63'd0, out_a}, (m_st[0] == S_NUM || m_st[0] == S_SPC) ? 64'sd1 : 64'sd0);
    chk("a_err", {63'd0, err_a}, (m_st[0] == S_ERR) ? 64'sd1 : 64'sd0);
    chk("a_ovf", {63'd0, ovf_a}, {63'd0, m_ovf[0]});
    chk("a_res", $signed(res_a), m_res[0]);
    chk("b_out", {63'd0, out_b}, (m_st[1] == S_NUM || m_st[1] == S_SPC) ? 64'sd1 : 64'sd0);
    chk("b_err", {63'd0, err_b}, (m_st[1] == S_ERR) ? 64'sd1 : 64'sd0);
    chk("b_ovf", {63'd0, ovf_b}, {63'd0, m_ovf[1]});
    chk("b_res", $signed(res_b), m_res[1]);
  endtask

  task automatic tick(input bit v, input byte c);
    in_valid = v;
    din = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (v) begin
      mstep(0, c);
      mstep(1, c);
    end
    compare_all();
  endtask

  task automatic do_clr(input byte c);
    clr = 1'b1;
    in_valid = 1'b1;
    din = c;
    @(posedge clk);
    #1;
    clr = 1'b0;
    in_valid = 1'b0;
    mreset(0);
    mreset(1);
    compare_all();
  endtask

  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) tick(1'b1, s[i]);
  endtask

  initial begin
    byte c;
    int  r;
    do_clr("0");
    chk("rst_res", $signed(res_a), 0);

    // "1+2*3": out toggles 1,0,1,0,1, result 7
    tick(1'b1, "1"); chk("t1_out1", {63'd0, out_a}, 1);
    tick(1'b1, "+"); chk("t1_out2", {63'd0, out_a}, 0);
    tick(1'b1, "2"); chk("t1_out3", {63'd0, out_a}, 1);
    tick(1'b1, "*"); chk("t1_out4", {63'd0, out_a}, 0);
    tick(1'b1, "3"); chk("t1_out5", {63'd0, out_a}, 1);
    chk("t1_res", $signed(res_a), 7);

    do_clr(" ");
    send("12 * 3 - 4");
    chk("t2_res", $signed(res_a), 32);
    chk("t2_out", {63'd0, out_a}, 1);

    do_clr(" ");
    send("1**");
    chk("t3_err", {63'd0, err_a}, 1);
    tick(1'b1, "2");
    chk("t3_out", {63'd0, out_a}, 0);
    do_clr(" ");
    chk("t3_clr_err", {63'd0, err_a}, 0);

    do_clr("2");
    send("+3");
    chk("t4_err", {63'd0, err_b}, 1);

    do_clr(" ");
    send("100*2");
    chk("t5_ovf", {63'd0, ovf_b}, 1);
`ifdef EXPR_SAT_EN
    chk("t5_res", $signed(res_b), 127);
`else
    chk("t5_res", $signed(res_b), -56);
`endif
    chk("t5_res_wide", $signed(res_a), 200);

    do_clr(" ");
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, byte'(8'h31 + i));
      tick(1'b0, "*");
      tick(1'b0, "q");
    end
    chk("t6_err", {63'd0, err_b}, 1);
    chk("t6_res", $signed(res_b), 123);
    chk("t6_wide", $signed(res_a), 1234);

    // randomized streams
    do_clr(" ");
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 50)      c = byte'(8'h30 + $urandom_range(0, 9));
      else if (r < 60) c = "+";
      else if (r < 68) c = "-";
      else if (r < 78) c = "*";
      else if (r < 90) c = " ";
      else if (r < 93) c = "x";
      else             c = "/";
      if ($urandom_range(0, 9) == 0) tick(1'b0, c);
      else tick(1'b1, c);
      if ((m_st[0] == S_ERR && $urandom_range(0, 2) == 0) || $urandom_range(0, 39) == 0)
        do_clr(c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
